// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed active-low 7-segment scan driver (option: LEADING_ZERO_BLANK_EN)
module seg7_scan_driver #(
    parameter int NDIGITS       = 8,
    parameter int PRESCALE_BITS = 17
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load,
    input  logic [4*NDIGITS-1:0]   value,
    input  logic [NDIGITS-1:0]     dp,
    input  logic [NDIGITS-1:0]     digit_en,
    output logic [NDIGITS-1:0]     digitselect,
    output logic [7:0]             segments,
    output logic                   frame_done
);

    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIGITS - 1);

    logic [4*NDIGITS-1:0]     value_q;
    logic [NDIGITS-1:0]       dp_q;
    logic [NDIGITS-1:0]       en_q;
    logic [PRESCALE_BITS-1:0] prescaler;
    logic [IDX_W-1:0]         idx;
    logic                     slot_end;
    logic [NDIGITS-1:0]       sel_d;
    logic [7:0]               seg_d;
    logic [3:0]               nib;
    logic [7:0]               pattern;

    // Pre-inversion {a,b,c,d,e,f,g,dp}; unknown nibbles light only the dp position
    function automatic logic [7:0] decode(input logic [3:0] n, input logic p);
        case (n)
            4'h0: decode = {7'b1111110, p};
            4'h1: decode = {7'b0110000, p};
            4'h2: decode = {7'b1101101, p};
            4'h3: decode = {7'b1111001, p};
            4'h4: decode = {7'b0110011, p};
            4'h5: decode = {7'b1011011, p};
            4'h6: decode = {7'b1011111, p};
            4'h7: decode = {7'b1110000, p};
            4'h8: decode = {7'b1111111, p};
            4'h9: decode = {7'b1111011, p};
            4'hA: decode = {7'b1110111, p};
            4'hB: decode = {7'b0011111, p};
            4'hC: decode = {7'b1001110, p};
            4'hD: decode = {7'b0111101, p};
            4'hE: decode = {7'b1001111, p};
            4'hF: decode = {7'b1000111, p};
            default: decode = 8'b00000001;
        endcase
    endfunction

    assign slot_end = &prescaler;

    // Shadow registers: reset clears them, load captures the CPU-side values
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            value_q <= '0;
            dp_q    <= '0;
            en_q    <= '0;
        end else if (load) begin
            value_q <= value;
            dp_q    <= dp;
            en_q    <= digit_en;
        end
    end

    // Free-running prescaler; digit index advances on the last cycle of each slot
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prescaler  <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
        end else begin
            prescaler  <= prescaler + 1'b1;
            frame_done <= slot_end && (idx == LAST_IDX);
            if (slot_end) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NDIGITS-1:0] zero_above;
    logic               zero_run;

    // zero_above[i] is set when nibbles i..NDIGITS-1 of the shadow value are all zero
    always_comb begin
        zero_above = '0;
        zero_run   = 1'b1;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run & (value_q[4*i +: 4] == 4'h0);
            zero_above[i] = zero_run;
        end
    end
`endif

    // Next output values for the digit currently being scanned
    always_comb begin
        nib     = value_q[idx*4 +: 4];
        pattern = decode(nib, dp_q[idx]);
`ifdef LEADING_ZERO_BLANK_EN
        if ((idx != '0) && zero_above[idx]) begin
            pattern[7:1] = 7'b0000000;
        end
`endif
        sel_d = '1;
        seg_d = 8'hFF;
        if (en_q[idx]) begin
            sel_d = ~(NDIGITS'(1) << idx);
            seg_d = ~pattern;
        end
    end

    // Selects and segments switch together on one edge: no intermediate state on the pins
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            digitselect <= '1;
            segments    <= 8'hFF;
        end else begin
            digitselect <= sel_d;
            segments    <= seg_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int PB = 2;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic          clk;
    logic          reset_n;
    logic          load;
    logic [4*ND-1:0] value;
    logic [ND-1:0] dp;
    logic [ND-1:0] digit_en;
    logic [ND-1:0] digitselect;
    logic [7:0]    segments;
    logic          frame_done;

    int checks;
    int failures;

    seg7_scan_driver #(.NDIGITS(ND), .PRESCALE_BITS(PB)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .value      (value),
        .dp         (dp),
        .digit_en   (digit_en),
        .digitselect(digitselect),
        .segments   (segments),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_load(input logic [15:0] v, input logic [3:0] p, input logic [3:0] e);
        value    = v;
        dp       = p;
        digit_en = e;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (frame_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        int dark_bad;
        int npulse;
        int first;
        int second;
        reset_n = 1'b0; load = 1'b0; value = '0; dp = '0; digit_en = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (digitselect !== 4'hF) begin failures++; $display("FAIL reset_sel: got %h expected f", digitselect); end
        checks++;
        if (segments !== 8'hFF) begin failures++; $display("FAIL reset_seg: got %h expected ff", segments); end
        checks++;
        if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_fd: got %b expected 0", frame_done); end
        reset_n = 1'b1;
        dark_bad = 0; npulse = 0; first = 0; second = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (digitselect !== 4'hF || segments !== 8'hFF) dark_bad++;
            if (frame_done === 1'b1) begin
                if (npulse == 0) first = c;
                else if (npulse == 1) second = c;
                npulse++;
            end
        end
        checks++;
        if (dark_bad != 0) begin failures++; $display("FAIL idle_dark: got %0d lit cycles expected 0", dark_bad); end
        checks++;
        if (npulse != 2) begin failures++; $display("FAIL idle_pulses: got %0d expected 2", npulse); end
        checks++;
        if (first != 16) begin failures++; $display("FAIL idle_first_fd: got cycle %0d expected 16", first); end
        checks++;
        if (second != 32) begin failures++; $display("FAIL idle_second_fd: got cycle %0d expected 32", second); end
    endtask

    task automatic test_scan_patterns;
        logic [15:0] tv  [3];
        logic [3:0]  tdp [3];
        logic [3:0]  ten [3];
        logic [3:0]  esel[3][4];
        logic [7:0]  eseg[3][4];
        bit ok;
        tv[0] = 16'h12AF; tdp[0] = 4'h0; ten[0] = 4'hF;
        esel[0] = '{4'hE, 4'hD, 4'hB, 4'h7};
        eseg[0] = '{8'h71, 8'h11, 8'h25, 8'h9F};
        tv[1] = 16'h0008; tdp[1] = 4'b0001; ten[1] = 4'b1011;
        esel[1] = '{4'hE, 4'hD, 4'hF, 4'h7};
        eseg[1] = '{8'h00, LZB ? 8'hFF : 8'h03, 8'hFF, LZB ? 8'hFF : 8'h03};
        tv[2] = 16'h0050; tdp[2] = 4'h0; ten[2] = 4'hF;
        esel[2] = '{4'hE, 4'hD, 4'hB, 4'h7};
        eseg[2] = '{8'h03, 8'h49, LZB ? 8'hFF : 8'h03, LZB ? 8'hFF : 8'h03};
        for (int t = 0; t < 3; t++) begin
            do_load(tv[t], tdp[t], ten[t]);
            wait_frame(ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL scan%0d_frame: got no frame_done expected pulse", t); end
            for (int d = 0; d < 4; d++) begin
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    checks++;
                    if (digitselect !== esel[t][d] || segments !== eseg[t][d]) begin
                        failures++;
                        $display("FAIL scan%0d_digit%0d_cyc%0d: got sel=%h seg=%h expected sel=%h seg=%h",
                                 t, d, c, digitselect, segments, esel[t][d], eseg[t][d]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_scan;
        bit ok;
        int first;
        do_load(16'h12AF, 4'h0, 4'hF);
        wait_frame(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rmid_frame: got no frame_done expected pulse"); end
        repeat (9) @(negedge clk);
        checks++;
        if (digitselect !== 4'hB || segments !== 8'h25) begin
            failures++; $display("FAIL rmid_pre: got sel=%h seg=%h expected sel=b seg=25", digitselect, segments);
        end
        reset_n = 1'b0; load = 1'b1; value = 16'hFFFF; dp = 4'hF; digit_en = 4'hF;
        @(negedge clk);
        checks++;
        if (digitselect !== 4'hF || segments !== 8'hFF || frame_done !== 1'b0) begin
            failures++; $display("FAIL rmid_reset: got sel=%h seg=%h fd=%b expected sel=f seg=ff fd=0",
                                 digitselect, segments, frame_done);
        end
        reset_n = 1'b1; value = 16'h12AF; dp = 4'h0; digit_en = 4'hF;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (digitselect !== 4'hF || segments !== 8'hFF) begin
            failures++; $display("FAIL rmid_shadow_clear: got sel=%h seg=%h expected sel=f seg=ff", digitselect, segments);
        end
        @(negedge clk);
        checks++;
        if (digitselect !== 4'hE || segments !== 8'h71) begin
            failures++; $display("FAIL rmid_restart_d0: got sel=%h seg=%h expected sel=e seg=71", digitselect, segments);
        end
        first = 0;
        for (int c = 3; c <= 20; c++) begin
            @(negedge clk);
            if (c == 5) begin
                checks++;
                if (digitselect !== 4'hD || segments !== 8'h11) begin
                    failures++; $display("FAIL rmid_d1: got sel=%h seg=%h expected sel=d seg=11", digitselect, segments);
                end
            end
            if (frame_done === 1'b1 && first == 0) first = c;
        end
        checks++;
        if (first != 16) begin failures++; $display("FAIL rmid_first_fd: got cycle %0d expected 16", first); end
    endtask

    task automatic test_load_on_wrap;
        bit ok;
        wait_frame(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL wrap_frame: got no frame_done expected pulse"); end
        repeat (3) @(negedge clk);
        value = 16'h3456; dp = 4'h0; digit_en = 4'hF; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (digitselect !== 4'hE || segments !== 8'h71) begin
            failures++; $display("FAIL wrap_old_d0: got sel=%h seg=%h expected sel=e seg=71", digitselect, segments);
        end
        @(negedge clk);
        checks++;
        if (digitselect !== 4'hD || segments !== 8'h49) begin
            failures++; $display("FAIL wrap_new_d1: got sel=%h seg=%h expected sel=d seg=49", digitselect, segments);
        end
        @(negedge clk);
        checks++;
        if (digitselect !== 4'hD || segments !== 8'h49) begin
            failures++; $display("FAIL wrap_new_d1_hold: got sel=%h seg=%h expected sel=d seg=49", digitselect, segments);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset_n = 1'b0; load = 1'b0; value = '0; dp = '0; digit_en = '0;
        test_reset;
        test_scan_patterns;
        test_reset_mid_scan;
        test_load_on_wrap;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
